// File: rtl/mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mul_sequencer
//  Purpose  : Iterative shift-and-add multiplier sequencer for a pipelined
//             CPU. While a MUL is in flight it stalls the IF/ID/EXE pipeline
//             registers. It then pulses done with the low WIDTH bits of
//             op_a*op_b.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH  - operand and result width in bits (default 32)
//  Ports
//    clk    in   sole clock, rising edge
//    rst    in   asynchronous active-high reset
//    start  in   is_mul from EXE decode, request to multiply
//    flush  in   branch flush, abandons any operation (priority over start)
//    op_a   in   multiplicand (Rm)
//    op_b   in   multiplier (Rs)
//    stall  out  freeze IF/ID/EXE registers (combinational)
//    busy   out  high while iterating (RUN)
//    done   out  one-cycle pulse, result valid
//    result out  low WIDTH bits of the product, held until next done/reset
//  Configuration
//    MUL_EARLY_TERM_EN - when defined, iteration stops as soon as the
//    remaining multiplier bits are all zero. A zero multiplier completes
//    straight from IDLE.
// ============================================================================
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;
  // Set for the cycle right after DONE. The MUL that just completed may still
  // hold start high there, and it must not launch a second multiply.
  logic             just_done;

  logic             accept;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] mplier_next;
  logic             last_iter;

  assign accept      = (state == IDLE) && start && !flush && !just_done;
  assign acc_next    = mplier[0] ? (acc + mcand) : acc;
  assign mplier_next = mplier >> 1;

`ifdef MUL_EARLY_TERM_EN
  assign last_iter = (count == CW'(WIDTH - 1)) || (mplier_next == '0);
`else
  assign last_iter = (count == CW'(WIDTH - 1));
`endif

  // The stall output is gated by rst so it drops immediately on reset even if
  // start is still high.
  assign stall = !rst && (accept || (state == RUN));
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
      result    <= '0;
      just_done <= 1'b0;
    end else begin
      just_done <= (state == DONE);
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              mcand  <= op_a;
              mplier <= op_b;
              acc    <= '0;
              count  <= '0;
`ifdef MUL_EARLY_TERM_EN
              if (op_b == '0) begin
                result <= '0;
                state  <= DONE;
              end else begin
                state  <= RUN;
              end
`else
              state  <= RUN;
`endif
            end
          end
          RUN: begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier_next;
            count  <= count + CW'(1);
            if (last_iter) begin
              // Capture the final sum now so result is valid throughout DONE.
              result <= acc_next;
              state  <= DONE;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_sequencer
//  Purpose  : Self-checking bench for mul_sequencer (WIDTH=32). The driver
//             pushes expected product and completion cycle into a scoreboard.
//             A separate monitor compares them on every done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mul_sequencer;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             start;
  logic             flush;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  mul_sequencer #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .op_a   (op_a),
    .op_b   (op_b),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [WIDTH-1:0] exp_res_q[$];
  int               exp_cyc_q[$];
  logic [WIDTH-1:0] last_res = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  // Reference model: plain arithmetic product, truncated.
  function automatic logic [WIDTH-1:0] model_prod(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] p;
    p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    return p[WIDTH-1:0];
  endfunction

  // Cycles from the start-sample cycle to the done cycle.
  function automatic int model_lat(input logic [WIDTH-1:0] b);
`ifdef MUL_EARLY_TERM_EN
    int msb;
    msb = -1;
    for (int i = 0; i < WIDTH; i++) if (b[i]) msb = i;
    return (b == '0) ? 1 : msb + 2;
`else
    return (b == b) ? WIDTH + 1 : 0;
`endif
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_res_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done @cycle %0d: got result 0x%08h expected no done", cyc, result);
      end else begin
        logic [WIDTH-1:0] er;
        int               ec;
        er = exp_res_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("result", result, er);
        check("done_cycle", WIDTH'(cyc), WIDTH'(ec));
        last_res = er;
      end
    end
  end

  // One multiply. hold keeps start high one cycle past done. nowait drives at
  // the current negedge instead of waiting for the next one.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input bit hold, input bit nowait);
    int c;
    int lat;
    if (!nowait) @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    c     = cyc;
    lat   = model_lat(b);
    exp_res_q.push_back(model_prod(a, b));
    exp_cyc_q.push_back(c + lat);
    #1 check("stall_accept", WIDTH'(stall), 1);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      #1;
      check("stall", WIDTH'(stall), WIDTH'(k < lat));
      check("busy", WIDTH'(busy), WIDTH'(k < lat));
    end
    if (hold) begin
      @(negedge clk);
      #1;
      check("stall_after_done", WIDTH'(stall), 0);
      check("busy_after_done", WIDTH'(busy), 0);
      start = 1'b0;
    end
    @(negedge clk);
    #1 check("scoreboard_drained", WIDTH'(exp_res_q.size()), 0);
  endtask

  initial begin
    int c;
    start = 1'b0;
    flush = 1'b0;
    op_a  = '0;
    op_b  = '0;
    rst   = 1'b0;
    #1 rst = 1'b1;
    start = 1'b1;
    #2;
    check("rst_stall", WIDTH'(stall), 0);
    check("rst_busy", WIDTH'(busy), 0);
    check("rst_done", WIDTH'(done), 0);
    check("rst_result", result, 0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed corners.
    run_op(32'd7, 32'd6, 1'b0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(32'd3, 32'd5, 1'b0, 1'b0);
    run_op(32'h1234_5678, 32'd0, 1'b0, 1'b0);
    run_op(32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    run_op(32'h8000_0000, 32'd2, 1'b0, 1'b0);
    // Start held through the cycle after done: exactly one result.
    run_op(32'd11, 32'd13, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    #1 check("no_retrigger_busy", WIDTH'(busy), 0);

    // Flush mid-RUN: back to IDLE, no done, result unchanged.
    @(negedge clk);
    op_a  = 32'd5;
    op_b  = 32'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_stall", WIDTH'(stall), 0);
    check("flush_busy", WIDTH'(busy), 0);
    check("flush_done", WIDTH'(done), 0);
    check("flush_result", result, last_res);
    repeat (40) @(negedge clk);

    // Asynchronous reset mid-RUN, then a start in the first free cycle.
    op_a  = 32'hABCD_0123;
    op_b  = 32'h0F0F_0F0F;
    start = 1'b1;
    c     = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < c + 12) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_stall", WIDTH'(stall), 0);
    check("arst_busy", WIDTH'(busy), 0);
    check("arst_done", WIDTH'(done), 0);
    check("arst_result", result, 0);
    last_res = '0;
    @(negedge clk);
    rst = 1'b0;
    run_op(32'h0001_0003, 32'h0000_0101, 1'b0, 1'b1);

    // Randomized operands, with a bias toward edge values.
    for (int i = 0; i < 16; i++) begin
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = $urandom_range(0, 15);
        1: a = '1;
        2: b = 32'h8000_0000 >> $urandom_range(0, 31);
        default: ;
      endcase
      run_op(a, b, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog @cycle %0d: got no end expected finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port start, input, 1, is_mul from the EXE-stage decode; request to multiply.
REQ-005 SHALL have port flush, input, 1, branch flush; abandons any operation.
REQ-006 SHALL have port op_a, input, WIDTH, multiplicand (Rm value).
REQ-007 SHALL have port op_b, input, WIDTH, multiplier (Rs value).
REQ-008 SHALL have port stall, output, 1, freezes IF/ID/EXE pipeline registers while high.
REQ-009 SHALL have port busy, output, 1, high in RUN.
REQ-010 SHALL have port done, output, 1, one-cycle pulse; result valid.
REQ-011 SHALL have port result, output, WIDTH, low WIDTH bits of op_a*op_b.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE: start=1 and flush=0 SHALL latch mcand=op_a, mplier=op_b, acc=0, count=0, and move to RUN.
REQ-014 RUN, each cycle: if mplier[0] then acc += mcand (mod 2^WIDTH); mcand <<= 1; mplier >>= 1; count += 1.
REQ-015 RUN SHALL move to DONE after the iteration where count==WIDTH-1 (WIDTH RUN cycles).
REQ-016 DONE SHALL assert done=1, drive result=acc, and return to IDLE on the next edge.
REQ-017 Latency: start sampled in cycle 0 SHALL give done in cycle WIDTH+1 (cycle 33 for WIDTH=32).
REQ-018 stall SHALL be combinational: (IDLE and start and not flush) or RUN; stall=0 in DONE so the held MUL advances.
REQ-019 start SHALL be ignored in RUN and DONE; a start still high during DONE SHALL NOT retrigger.
REQ-020 flush in any state SHALL force IDLE on the next edge, with no done pulse; flush has priority over start.
REQ-021 result SHALL hold its last DONE value until the next DONE or reset; done=0 outside DONE.
REQ-022 Overflow above WIDTH bits SHALL be discarded; no flags produced (CPSR update handled elsewhere).

Reset
REQ-023 rst=1 SHALL immediately force IDLE, stall=0, busy=0, done=0, result=0, acc/mcand/mplier/count=0, including mid-RUN.
REQ-024 First start SHALL be accepted in the first cycle after rst deasserts.

Configuration
REQ-025 Macro MUL_EARLY_TERM_EN defined: RUN SHALL move to DONE after an iteration whose shifted mplier is 0, and IDLE start with op_b==0 SHALL go directly to DONE (done in cycle 1, result 0).
REQ-026 MUL_EARLY_TERM_EN undefined: always exactly WIDTH RUN cycles regardless of operand values; latency fixed per REQ-017.

Verification
REQ-027 op_a=7, op_b=6, start in cycle 0 (macro off) -> stall high cycles 0..32, done=1 cycle 33, result=0x0000002A.
REQ-028 op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> result=0x00000001 on done.
REQ-029 start cycle 0, flush cycle 10 -> IDLE in cycle 11, stall=0, no done; result keeps prior value.
REQ-030 start held high through cycle 34 -> exactly one done pulse (cycle 33), stall=0 in cycles 33-34 with no new RUN entry.
REQ-031 MUL_EARLY_TERM_EN, op_a=3, op_b=5 -> done cycle 4, result=15; op_b=0 -> done cycle 1, result=0.
REQ-032 rst asserted asynchronously mid-RUN (cycle 12) -> all outputs 0 before next clock edge; new start after release completes correctly.
